// File: rtl/ewb_coalesce.sv
// ewb_coalesce -- eviction write buffer with write coalescing.
//
// Queues dirty lines evicted from L2 in FIFO order and drains them toward
// memory through a valid/yumi handshake. A line that is re-evicted while a
// non-head copy is still queued overwrites that copy in place. The head
// entry is frozen while queued, so a re-eviction of the head line allocates
// a fresh entry instead. A combinational lookup port returns the youngest
// queued copy of a line for L2 miss snooping.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   valid_i         enqueue request
//   data_i, addr_i  evicted line data and byte address (offset bits ignored)
//   ready_o         enqueue accepted when valid_i & ready_o
//   lookup_i        snoop request
//   lookup_addr_i   line address to snoop
//   lookup_hit_o    snooped line is queued
//   lookup_data_o   data of the youngest matching entry (0 on miss)
//   valid_o         head entry available
//   data_o, addr_o  head data and line-aligned address (0 when empty)
//   yumi_i          consumer takes the head this cycle
//   empty_o, full_o, count_o  occupancy status
module ewb_coalesce #(
  parameter int WIDTH  = 256,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int OFFSET = 5,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LINE_W = ADDR_W - OFFSET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              ready_o,
  input  logic              lookup_i,
  input  logic [LINE_W-1:0] lookup_addr_i,
  output logic              lookup_hit_o,
  output logic [WIDTH-1:0]  lookup_data_o,
  output logic              valid_o,
  output logic [WIDTH-1:0]  data_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic              yumi_i,
  output logic              empty_o,
  output logic              full_o,
  output logic [PTR_W:0]    count_o
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [LINE_W-1:0] addr_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]    count_q;

  logic [LINE_W-1:0] line_in;
  logic              unused_offset;
  logic              coal_hit;
  logic [PTR_W-1:0]  coal_idx;
  logic [PTR_W-1:0]  wr_idx;
  logic              enq, alloc, deq;

  assign line_in       = addr_i[ADDR_W-1:OFFSET];
  // Offset bits are intentionally dropped: storage is per line.
  assign unused_offset = ^addr_i[OFFSET-1:0];

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign valid_o = !empty_o;

  // Coalesce target: a valid entry other than the head holding the same line.
  // The head is excluded so the consumer always sees stable head data.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path can leave a value held (latch inferred).
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i && vld_q[i] && (PTR_W'(i) != rd_ptr_q) && (addr_q[i] == line_in)) begin
        coal_hit = 1'b1;
        coal_idx = PTR_W'(i);
      end
    end
  end

  // A slot freed by a same-cycle dequeue is not reusable until the next cycle.
  assign ready_o = !full_o || coal_hit;
  assign enq     = valid_i && ready_o;
  assign alloc   = enq && !coal_hit;
  assign deq     = yumi_i && !empty_o;
  assign wr_idx  = coal_hit ? coal_idx : wr_ptr_q;

  // Walk from oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx           = '0;
    lookup_hit_o  = 1'b0;
    lookup_data_o = '0;
    if (lookup_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr_q + PTR_W'(k);
        if (vld_q[idx] && (addr_q[idx] == lookup_addr_i)) begin
          lookup_hit_o  = 1'b1;
          lookup_data_o = data_q[idx];
        end
      end
    end
  end

  assign data_o = empty_o ? '0 : data_q[rd_ptr_q];
  assign addr_o = empty_o ? '0 : {addr_q[rd_ptr_q], {OFFSET{1'b0}}};

  // Control state. alloc and deq never target the same slot: the pointers
  // are equal only when empty (no deq) or full (no alloc).
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples the pre-edge values, independent of statement order.
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (alloc) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (deq) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PTR_ONE;
      end
      if (alloc && !deq) begin
        count_q <= count_q + CNT_ONE;
      end else if (deq && !alloc) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  // NOTE: the data/address arrays carry no reset; the valid bits alone decide
  // whether an entry is live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (enq) begin
      data_q[wr_idx] <= data_i;
    end
    if (alloc) begin
      addr_q[wr_ptr_q] <= line_in;
    end
  end

endmodule

// File: tb/tb_ewb_coalesce.sv
// Self-checking bench for ewb_coalesce: directed stimulus feeds a reference
// FIFO-with-coalescing model; a monitor pops and compares on every dequeue.
module tb_ewb_coalesce;

  localparam int WIDTH  = 256;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int OFFSET = 5;
  localparam int PTR_W  = 3;
  localparam int LINE_W = ADDR_W - OFFSET;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i;
  logic [WIDTH-1:0]  data_i;
  logic [ADDR_W-1:0] addr_i;
  logic              ready_o;
  logic              lookup_i;
  logic [LINE_W-1:0] lookup_addr_i;
  logic              lookup_hit_o;
  logic [WIDTH-1:0]  lookup_data_o;
  logic              valid_o;
  logic [WIDTH-1:0]  data_o;
  logic [ADDR_W-1:0] addr_o;
  logic              yumi_i;
  logic              empty_o;
  logic              full_o;
  logic [PTR_W:0]    count_o;

  ewb_coalesce #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .data_i(data_i), .addr_i(addr_i), .ready_o(ready_o),
    .lookup_i(lookup_i), .lookup_addr_i(lookup_addr_i),
    .lookup_hit_o(lookup_hit_o), .lookup_data_o(lookup_data_o),
    .valid_o(valid_o), .data_o(data_o), .addr_o(addr_o), .yumi_i(yumi_i),
    .empty_o(empty_o), .full_o(full_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LINE_W-1:0] line;
    logic [WIDTH-1:0]  data;
  } ent_t;

  ent_t sb[$];
  bit   head_avail = 1'b0;  // model had a head before this cycle's enqueue
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [WIDTH-1:0] pat(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [LINE_W-1:0] ln(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFFSET];
  endfunction

  // Monitor: every dequeue the DUT performs is compared against the model head.
  always @(negedge clk) begin
    if (!rst && yumi_i && (valid_o || head_avail)) begin
      check("valid_o_on_yumi", valid_o, head_avail);
      if (sb.size() != 0) begin
        ent_t e;
        e = sb.pop_front();
        check("deq_data", data_o, e.data);
        check("deq_addr", addr_o, {e.line, {OFFSET{1'b0}}});
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic v, input logic [ADDR_W-1:0] a,
                       input logic [WIDTH-1:0] d, input logic y,
                       input logic lk, input logic [LINE_W-1:0] la);
    int   m;
    logic eh, er;
    logic [WIDTH-1:0] ed;
    valid_i = v; addr_i = a; data_i = d; yumi_i = y;
    lookup_i = lk; lookup_addr_i = la;
    #1;
    if (lk) begin
      eh = 1'b0; ed = '0;
      for (int j = 0; j < sb.size(); j++)
        if (sb[j].line == la) begin eh = 1'b1; ed = sb[j].data; end
      check("lookup_hit", lookup_hit_o, eh);
      check("lookup_data", lookup_data_o, ed);
    end
    m = -1;
    for (int j = 1; j < sb.size(); j++)
      if (sb[j].line == ln(a)) m = j;
    er = (sb.size() < DEPTH) || (v && m >= 0);
    check("ready_o", ready_o, er);
    head_avail = (sb.size() != 0);
    if (v && er) begin
      if (m >= 0) sb[m].data = d;
      else sb.push_back('{line: ln(a), data: d});
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0; yumi_i = 1'b0; lookup_i = 1'b0;
    check("count_o", count_o, sb.size());
    check("empty_o", empty_o, sb.size() == 0);
    check("full_o", full_o, sb.size() == DEPTH);
  endtask

  task automatic enq(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    cycle(1'b1, a, d, 1'b0, 1'b0, '0);
  endtask

  task automatic drain();
    for (int b = 0; b < 64 && sb.size() > 0; b++)
      cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
    check("drain_done", sb.size(), 0);
    check("drained_empty", empty_o, 1'b1);
    check("drained_data", data_o, '0);
    check("drained_addr", addr_o, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; data_i = '0; addr_i = '0; yumi_i = 1'b0;
    lookup_i = 1'b1; lookup_addr_i = ln(32'h1000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 1'b1);
    check("rst_full", full_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_data", data_o, '0);
    check("rst_addr", addr_o, '0);
    check("rst_lookup_hit", lookup_hit_o, 1'b0);
    check("rst_lookup_data", lookup_data_o, '0);
    check("rst_ready", ready_o, 1'b1);
    rst = 1'b0; lookup_i = 1'b0;

    // 1: basic FIFO order, line-aligned addresses
    enq(32'h1004, pat(8'hD1));
    enq(32'h2000, pat(8'hD2));
    enq(32'h3010, pat(8'hD3));
    check("t1_count", count_o, 3);
    check("t1_head_addr", addr_o, 32'h1000);
    check("t1_head_data", data_o, pat(8'hD1));
    drain();

    // 2: coalesce into a non-head entry
    enq(32'h1000, pat(8'hD1));
    enq(32'h2000, pat(8'hD2));
    enq(32'h2000, pat(8'hBB));
    check("t2_count", count_o, 2);
    drain();

    // 3: head freeze, duplicate of head allocates, lookup returns youngest
    enq(32'h1000, pat(8'hD1));
    enq(32'h1000, pat(8'hAA));
    check("t3_count", count_o, 2);
    check("t3_head_frozen", data_o, pat(8'hD1));
    cycle(1'b0, '0, '0, 1'b0, 1'b1, ln(32'h1000));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
    check("t3_new_head", data_o, pat(8'hAA));
    drain();

    // 4: full behaviour
    for (int i = 0; i < DEPTH; i++)
      enq(32'h10000 + 32'(i) * 32'h100, pat(8'h40 + 8'(i)));
    check("t4_full", full_o, 1'b1);
    enq(32'h9000, pat(8'h99));                       // refused
    enq(32'h10300, pat(8'hEE));                      // coalesces into entry 3
    check("t4_count", count_o, 8);
    cycle(1'b1, 32'h9000, pat(8'h99), 1'b1, 1'b0, '0); // only the dequeue
    check("t4_after_deq", count_o, 7);
    drain();

    // 5: concurrency and pointer wrap
    for (int i = 0; i < 4; i++) enq(32'h20000 + 32'(i) * 32'h20, pat(8'h60 + 8'(i)));
    cycle(1'b1, 32'h21000, pat(8'h70), 1'b1, 1'b0, '0);
    check("t5_alloc_deq", count_o, 4);
    for (int i = 0; i < 20; i++)
      cycle(i % 4 != 3, 32'h5000 + 32'(i % 5) * 32'h20 + 32'(i % 4),
            {8{32'(i) ^ 32'hA5A5_0000}}, i % 3 != 0, i % 2 == 1,
            ln(32'h5000 + 32'((i + 2) % 5) * 32'h20));
    drain();

    // 6: reset mid-operation
    for (int i = 0; i < 5; i++) enq(32'h30000 + 32'(i) * 32'h20, pat(8'h80 + 8'(i)));
    check("t6_count", count_o, 5);
    rst = 1'b1;
    sb.delete();
    head_avail = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_empty", empty_o, 1'b1);
    check("t6_count0", count_o, 0);
    check("t6_valid", valid_o, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, ln(32'h30020));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);              // yumi while empty ignored

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
